instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Dual-lane instruction buffer between the decoder and dispatch.
- Accepts up to two decoded instructions per cycle, in program order.
- Presents the two oldest entries to dispatch and retires 0, 1 or 2 of them per cycle, according to the issue mask dispatch returns.
- Decouples decode throughput from dispatch stalls (load-use, TLB hazards, single-issue pairs).

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- ENTRY_W, 256, width of one decoded-instruction record; bits [31:0] hold the PC.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  pipeline flush; empties the queue
- pause  in  1  global stall; pops are ignored while high
- enq_valid  in  2  lane-valid mask from the decoder; bit0 is the older lane
- enq_data  in  2*ENTRY_W  decoded records; lane0 in the low half
- enq_ready  out  1  at least two free entries this cycle
- head_valid  out  2  bit i set when head slot i holds an entry
- head_data  out  2*ENTRY_W  the two oldest entries; slot0 is the oldest
- pop_mask  in  2  issue mask from dispatch
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- State:
  - storage array of DEPTH x ENTRY_W
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH
  - count register
- Reset (rst=1 at posedge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Storage contents are don't-care.
  - In the cycle after reset: head_valid=2'b00, head_data all-zero, enq_ready=1, count=0.
- Head outputs are combinational from the registered state.
  - head_valid[0] = (count>=1); head_valid[1] = (count>=2).
  - head_data[i] = storage[rd_ptr+i] when head_valid[i], else all-zero. Dispatch treats PC==0 as invalid, so zeroing is mandatory.
- Pop count:
  - npop = 0 if pause or flush.
  - Otherwise: pop_mask 2'b01 pops 1; 2'b11 pops 2; 2'b00 pops 0.
  - 2'b10 is illegal and pops 0.
  - Popping beyond head_valid is clamped: npop = min(npop, count).
- Enqueue:
  - enq_ready = (DEPTH - count >= 2). It is computed from the registered count only; same-cycle pops are not credited.
  - A lane writes only when enq_ready && !flush && enq_valid[i].
  - Lanes are compacted in order:
    - 2'b11 writes lane0 at wr_ptr and lane1 at wr_ptr+1.
    - 2'b01 writes lane0 at wr_ptr.
    - 2'b10 writes lane1 at wr_ptr.
  - nenq = popcount of the accepted lanes.
  - Enqueue is all-or-nothing per cycle; the decoder holds its data while enq_ready=0.
- Update at posedge when not rst/flush:
  - rd_ptr += npop, wr_ptr += nenq, count += nenq - npop.
  - Enqueue and pop in the same cycle are both applied.
  - An entry enqueued this cycle is never visible at the head until the next cycle (no bypass).
- Flush:
  - Takes priority over everything: rd_ptr=wr_ptr=0, count=0.
  - Same-cycle enqueue and pop are discarded.
  - head_valid=0 from the next cycle.
- Pause: blocks pops only. Enqueue continues while enq_ready=1.
- Wrap-around: pointers wrap silently; the two head slots may straddle index DEPTH-1 and index 0.
- Overflow is impossible by construction. Underflow is prevented by the pop clamp.
- Assertions for the bench:
  - count <= DEPTH at all times.
  - pop_mask != 2'b10 whenever head_valid[0].

Test Plan:
- Reset, then idle → head_valid=00, head_data=0, enq_ready=1, count=0.
- Enqueue pairs PC 0x1c000000/04, then 08/0c, no pops → count=4; head slot0=0x1c000000, slot1=0x1c000004.
- Then pop_mask=11 for one cycle → next cycle count=2, heads 08/0c. Then pop_mask=01 → count=1, head_valid=01, slot1 data=0.
- Fill to DEPTH-1 (7 entries) → enq_ready=0. Decoder holds valid=11 and is not accepted. Pop 2 → enq_ready=1 next cycle and the pair is written. Then pop 1 per cycle for 8 cycles → FIFO order is preserved across the wrap.
- Same-cycle enqueue 11 and pop 11 at count=2 → count stays 2; head becomes the new pair the next cycle.
- flush with enq_valid=11 and pop_mask=11 at count=5 → count=0, head_valid=00 next cycle; no entry written.
- pause=1 with pop_mask=11 and count=3 → count unchanged and heads unchanged. Simultaneous enq 01 → count=4.

Source files
------------

// File: rtl/instr_queue_if.sv
// Decoder/dispatch side bundle for the dual-lane instruction queue.
// Master drives enqueue/pop controls; slave is the queue itself.
interface instr_queue_if #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 256
);
  logic                     flush;
  logic                     pause;
  logic [1:0]               enq_valid;
  logic [2*ENTRY_W-1:0]     enq_data;
  logic                     enq_ready;
  logic [1:0]               head_valid;
  logic [2*ENTRY_W-1:0]     head_data;
  logic [1:0]               pop_mask;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, pause, enq_valid, enq_data, pop_mask,
    input  enq_ready, head_valid, head_data, count
  );

  modport slave (
    input  flush, pause, enq_valid, enq_data, pop_mask,
    output enq_ready, head_valid, head_data, count
  );
endinterface

// File: rtl/instr_queue.sv
// Dual-lane in-order instruction buffer between decode and dispatch.
// Two-wide enqueue, two-wide head window, clamped 0/1/2 retire per cycle.
module instr_queue #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 256
) (
  input  logic           clk,
  input  logic           rst,
  instr_queue_if.slave   q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               ready;
  logic [1:0]         acc;
  logic [1:0]         nenq;
  logic [1:0]         npop_req;
  logic [1:0]         npop;
  logic               we0, we1;
  logic [AW-1:0]      wa0, wa1;
  logic [ENTRY_W-1:0] wd0, wd1;
  logic [ENTRY_W-1:0] lane0, lane1;
  logic [AW-1:0]      rd1;
  logic [1:0]         hv;

  assign lane0 = q.enq_data[ENTRY_W-1:0];
  assign lane1 = q.enq_data[2*ENTRY_W-1:ENTRY_W];

  // Space for a full pair, judged on registered occupancy only.
  assign ready = (count_q <= CW'(DEPTH - 2));

  // Retire count from the issue mask, clamped to what is present.
  always_comb begin
    npop_req = 2'd0;
    if (!q.pause && !q.flush) begin
      unique case (1'b1)
        (q.pop_mask == 2'b11): npop_req = 2'd2;
        (q.pop_mask == 2'b01): npop_req = 2'd1;
        default:               npop_req = 2'd0;
      endcase
    end
    npop = npop_req;
    if (CW'(npop_req) > count_q) npop = count_q[1:0];
  end

  // Accepted lanes, compacted so the oldest valid lane lands at wr_ptr.
  always_comb begin
    acc  = (ready && !q.flush) ? q.enq_valid : 2'b00;
    nenq = {1'b0, acc[0]} + {1'b0, acc[1]};
    we0  = |acc;
    we1  = &acc;
    wa0  = wr_ptr_q;
    wa1  = wr_ptr_q + AW'(1);
    wd0  = acc[0] ? lane0 : lane1;
    wd1  = lane1;
  end

  // Pointer and occupancy next-state; flush wins over enqueue and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(npop);
    wr_ptr_d = wr_ptr_q + AW'(nenq);
    count_d  = count_q + CW'(nenq) - CW'(npop);
    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are irrelevant until counted in.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wa0] <= wd0;
    if (we1) mem_q[wa1] <= wd1;
  end

  assign rd1 = rd_ptr_q + AW'(1);
  assign hv  = {count_q >= CW'(2), count_q != '0};

  assign q.enq_ready  = ready;
  assign q.count      = count_q;
  assign q.head_valid = hv;
  assign q.head_data  = {hv[1] ? mem_q[rd1]      : '0,
                         hv[0] ? mem_q[rd_ptr_q] : '0};
endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with a queue-based reference model.
// Model checked every cycle, plus literal spot checks along the way.
module tb_instr_queue;
  localparam int DEPTH   = 8;
  localparam int ENTRY_W = 256;

  logic clk = 1'b0;
  logic rst;
  logic chk_en;
  int   checks   = 0;
  int   failures = 0;

  logic [ENTRY_W-1:0] mq[$];

  instr_queue_if #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) bus ();

  instr_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [ENTRY_W-1:0] rec(input logic [31:0] pc);
    return {{7{~pc}}, pc};
  endfunction

  task automatic chk(input string nm,
                     input logic [ENTRY_W-1:0] act,
                     input logic [ENTRY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: plain FIFO of records, updated on each rising edge.
  always @(posedge clk) begin : model
    int n;
    int np;
    bit rdy;
    n   = mq.size();
    rdy = (DEPTH - n) >= 2;
    if (rst || bus.flush) begin
      mq.delete();
    end else begin
      np = 0;
      if (!bus.pause) begin
        if (bus.pop_mask == 2'b01) np = 1;
        if (bus.pop_mask == 2'b11) np = 2;
      end
      if (np > n) np = n;
      for (int i = 0; i < np; i++) void'(mq.pop_front());
      if (rdy) begin
        if (bus.enq_valid[0]) mq.push_back(bus.enq_data[ENTRY_W-1:0]);
        if (bus.enq_valid[1]) mq.push_back(bus.enq_data[2*ENTRY_W-1:ENTRY_W]);
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin : cmp
    int n;
    logic [ENTRY_W-1:0] e0, e1;
    if (chk_en) begin
      n  = mq.size();
      e0 = (n >= 1) ? mq[0] : '0;
      e1 = (n >= 2) ? mq[1] : '0;
      chk("head_valid", ENTRY_W'(bus.head_valid),
          ENTRY_W'({n >= 2, n >= 1}));
      chk("head0", bus.head_data[ENTRY_W-1:0], e0);
      chk("head1", bus.head_data[2*ENTRY_W-1:ENTRY_W], e1);
      chk("count", ENTRY_W'(bus.count), ENTRY_W'(n));
      chk("enq_ready", ENTRY_W'(bus.enq_ready),
          ENTRY_W'((DEPTH - n) >= 2));
      chk("count_le_depth", ENTRY_W'(bus.count <= DEPTH), ENTRY_W'(1));
      if (bus.head_valid[0])
        chk("pop_mask_legal", ENTRY_W'(bus.pop_mask != 2'b10),
            ENTRY_W'(1));
    end
  end

  task automatic cyc(input logic f, input logic p,
                     input logic [1:0] ev,
                     input logic [31:0] p0, input logic [31:0] p1,
                     input logic [1:0] pm);
    bus.flush     = f;
    bus.pause     = p;
    bus.enq_valid = ev;
    bus.enq_data  = {rec(p1), rec(p0)};
    bus.pop_mask  = pm;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    chk(nm, ENTRY_W'(act), ENTRY_W'(exp));
  endtask

  localparam logic [31:0] B = 32'h1c000000;
  localparam logic [31:0] X = 32'hdeadbeef;

  initial begin
    chk_en        = 1'b0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.pause     = 1'b0;
    bus.enq_valid = 2'b00;
    bus.enq_data  = '0;
    bus.pop_mask  = 2'b00;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    lit("rst_count", 32'(bus.count), 0);
    lit("rst_hv", 32'(bus.head_valid), 0);
    lit("rst_ready", 32'(bus.enq_ready), 1);
    chk("rst_hdata_lo", bus.head_data[ENTRY_W-1:0], '0);
    chk("rst_hdata_hi", bus.head_data[2*ENTRY_W-1:ENTRY_W], '0);

    cyc(0, 0, 2'b00, X, X, 2'b00);
    cyc(0, 0, 2'b11, B + 0, B + 4, 2'b00);
    cyc(0, 0, 2'b11, B + 8, B + 12, 2'b00);
    lit("pair_count", 32'(bus.count), 4);
    lit("pair_h0", bus.head_data[31:0], B);
    lit("pair_h1", bus.head_data[ENTRY_W+31:ENTRY_W], B + 4);

    cyc(0, 0, 2'b00, X, X, 2'b11);
    lit("pop2_count", 32'(bus.count), 2);
    lit("pop2_h0", bus.head_data[31:0], B + 8);
    lit("pop2_h1", bus.head_data[ENTRY_W+31:ENTRY_W], B + 12);
    cyc(0, 0, 2'b00, X, X, 2'b01);
    lit("pop1_count", 32'(bus.count), 1);
    lit("pop1_hv", 32'(bus.head_valid), 1);
    lit("pop1_h1", bus.head_data[ENTRY_W+31:ENTRY_W], 0);

    cyc(0, 0, 2'b11, B + 16, B + 20, 2'b00);
    cyc(0, 0, 2'b11, B + 24, B + 28, 2'b00);
    cyc(0, 0, 2'b11, B + 32, B + 36, 2'b00);
    lit("full_count", 32'(bus.count), 7);
    lit("full_ready", 32'(bus.enq_ready), 0);
    cyc(0, 0, 2'b11, B + 40, B + 44, 2'b00);
    lit("held_count", 32'(bus.count), 7);
    cyc(0, 0, 2'b11, B + 40, B + 44, 2'b11);
    lit("drain_count", 32'(bus.count), 5);
    lit("drain_ready", 32'(bus.enq_ready), 1);
    lit("drain_h0", bus.head_data[31:0], B + 20);
    cyc(0, 0, 2'b11, B + 40, B + 44, 2'b00);
    lit("refill_count", 32'(bus.count), 7);
    for (int i = 0; i < 8; i++) cyc(0, 0, 2'b00, X, X, 2'b01);
    lit("wrap_empty", 32'(bus.count), 0);

    cyc(0, 0, 2'b11, B + 64, B + 68, 2'b00);
    cyc(0, 0, 2'b11, B + 72, B + 76, 2'b11);
    lit("swap_count", 32'(bus.count), 2);
    lit("swap_h0", bus.head_data[31:0], B + 72);
    lit("swap_h1", bus.head_data[ENTRY_W+31:ENTRY_W], B + 76);

    cyc(0, 0, 2'b11, B + 80, B + 84, 2'b00);
    cyc(0, 0, 2'b01, B + 88, X, 2'b00);
    lit("preflush_count", 32'(bus.count), 5);
    cyc(1, 0, 2'b11, B + 112, B + 116, 2'b11);
    lit("flush_count", 32'(bus.count), 0);
    lit("flush_hv", 32'(bus.head_valid), 0);
    cyc(0, 0, 2'b01, B + 96, X, 2'b00);
    lit("postflush_h0", bus.head_data[31:0], B + 96);
    lit("postflush_hv", 32'(bus.head_valid), 1);

    cyc(0, 0, 2'b11, B + 100, B + 104, 2'b00);
    cyc(0, 1, 2'b00, X, X, 2'b11);
    lit("pause_count", 32'(bus.count), 3);
    lit("pause_h0", bus.head_data[31:0], B + 96);
    lit("pause_h1", bus.head_data[ENTRY_W+31:ENTRY_W], B + 100);
    cyc(0, 1, 2'b01, B + 108, X, 2'b11);
    lit("pause_enq_count", 32'(bus.count), 4);

    cyc(0, 0, 2'b10, X, B + 120, 2'b00);
    lit("lane1_count", 32'(bus.count), 5);
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, X, X, 2'b11);
    lit("final_count", 32'(bus.count), 0);
    cyc(0, 0, 2'b00, X, X, 2'b00);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
